// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pixel_out
//  Purpose  : VGA raster timing generator and final pixel output stage.
//             Expands RRRGGGBB to 8-bit channels, aligned with sync/blank.
//  Revision : 1.0  initial release
// ============================================================================

module vga_pixel_out #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int RGB_LAT   = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN
);

  localparam logic [10:0] c_H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] c_V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] c_H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] c_V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] c_HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] c_HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] c_VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] c_VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  // Idle timing bits packed as {vis, hs, vs}: blanked, both syncs inactive
  localparam logic [2:0]  c_IDLE     = 3'b011;

  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic        w_h_wrap;
  logic        w_v_wrap;

  assign w_h_wrap = (r_hcnt == c_H_LAST);
  assign w_v_wrap = (r_vcnt == c_V_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_wrap) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_wrap ? 11'd0 : r_vcnt + 11'd1;
    end else begin
      r_hcnt <= r_hcnt + 11'd1;
    end
  end

  assign pixelX       = r_hcnt;
  assign pixelY       = r_vcnt;
  assign startOfFrame = (r_hcnt == 11'd0) && (r_vcnt == 11'd0);

  logic       w_vis;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [2:0] w_raw;
  logic [2:0] w_aligned;

  assign w_vis    = (r_hcnt < c_H_VIS) && (r_vcnt < c_V_VIS);
  assign w_hs_raw = !((r_hcnt >= c_HS_START) && (r_hcnt < c_HS_END));
  assign w_vs_raw = !((r_vcnt >= c_VS_START) && (r_vcnt < c_VS_END));
  assign w_raw    = {w_vis, w_hs_raw, w_vs_raw};

  // Timing bits are delayed to match the upstream layers' pixel latency
  generate
    if (RGB_LAT == 0) begin : g_direct
      assign w_aligned = w_raw;
    end else begin : g_delay
      logic [2:0] r_dly [RGB_LAT];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < RGB_LAT; i++) begin
            r_dly[i] <= c_IDLE;
          end
        end else begin
          r_dly[0] <= w_raw;
          for (int i = 1; i < RGB_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_aligned = r_dly[RGB_LAT-1];
    end
  endgenerate

  logic [7:0] w_red;
  logic [7:0] w_green;
  logic [7:0] w_blue;

  // Bit replication maps full-scale codes to 8'hFF and zero to 8'h00
  assign w_red   = {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
  assign w_green = {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
  assign w_blue  = {4{RGBIn[1:0]}};

  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blankN;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_red    <= 8'h00;
      r_green  <= 8'h00;
      r_blue   <= 8'h00;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_blankN <= 1'b0;
    end else begin
      r_blankN <= w_aligned[2];
      r_hsync  <= w_aligned[1];
      r_vsync  <= w_aligned[0];
      r_red    <= w_aligned[2] ? w_red   : 8'h00;
      r_green  <= w_aligned[2] ? w_green : 8'h00;
      r_blue   <= w_aligned[2] ? w_blue  : 8'h00;
    end
  end

  assign red    = r_red;
  assign green  = r_green;
  assign blue   = r_blue;
  assign hsync  = r_hsync;
  assign vsync  = r_vsync;
  assign blankN = r_blankN;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pixel_out
//  Purpose  : Directed self-checking bench; three reduced-raster instances
//             (RGB_LAT 0/1/3) plus one full 640x480 instance for line timing.
//  Revision : 1.0  initial release
// ============================================================================

module tb_vga_pixel_out;

  // Reduced raster: 16+2+4+3 = 25 clocks/line, 8+2+2+3 = 15 lines/frame
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = 25, VT = 15, FT = 375;
  localparam int LATS [3] = '{0, 1, 3};

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic [7:0] RGBIn = 8'h00;

  always #5 clk = ~clk;

  logic [10:0] px [3];
  logic [10:0] py [3];
  logic        sof [3];
  logic [7:0]  rr [3];
  logic [7:0]  gg [3];
  logic [7:0]  bb [3];
  logic        hs [3];
  logic        vs [3];
  logic        bn [3];

  logic [10:0] dd_px, dd_py;
  logic        dd_sof, dd_hs, dd_vs, dd_bn;
  logic [7:0]  dd_r, dd_g, dd_b;

  int errors = 0;
  int checks = 0;

  vga_pixel_out #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                  .RGB_LAT(0)) u_lat0 (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .pixelX(px[0]), .pixelY(py[0]),
    .startOfFrame(sof[0]), .red(rr[0]), .green(gg[0]), .blue(bb[0]),
    .hsync(hs[0]), .vsync(vs[0]), .blankN(bn[0]));

  vga_pixel_out #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                  .RGB_LAT(1)) u_lat1 (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .pixelX(px[1]), .pixelY(py[1]),
    .startOfFrame(sof[1]), .red(rr[1]), .green(gg[1]), .blue(bb[1]),
    .hsync(hs[1]), .vsync(vs[1]), .blankN(bn[1]));

  vga_pixel_out #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                  .RGB_LAT(3)) u_lat3 (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .pixelX(px[2]), .pixelY(py[2]),
    .startOfFrame(sof[2]), .red(rr[2]), .green(gg[2]), .blue(bb[2]),
    .hsync(hs[2]), .vsync(vs[2]), .blankN(bn[2]));

  vga_pixel_out u_full (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .pixelX(dd_px), .pixelY(dd_py),
    .startOfFrame(dd_sof), .red(dd_r), .green(dd_g), .blue(dd_b),
    .hsync(dd_hs), .vsync(dd_vs), .blankN(dd_bn));

  // Sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 resetN = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
  endtask

  task automatic test_reset();
    logic [49:0] rst_vec;
    rst_vec = {11'd0, 11'd0, 1'b1, 24'd0, 3'b110};
    RGBIn = 8'h00;
    repeat (5) @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({px[k], py[k], sof[k], rr[k], gg[k], bb[k], hs[k], vs[k], bn[k]} !== rst_vec) begin
        errors++;
        $display("FAIL reset_async lat%0d: got %h expected %h", LATS[k],
                 {px[k], py[k], sof[k], rr[k], gg[k], bb[k], hs[k], vs[k], bn[k]}, rst_vec);
      end
    end
    checks++;
    if ({dd_px, dd_py, dd_sof, dd_r, dd_g, dd_b, dd_hs, dd_vs, dd_bn} !== rst_vec) begin
      errors++;
      $display("FAIL reset_async full: got %h expected %h",
               {dd_px, dd_py, dd_sof, dd_r, dd_g, dd_b, dd_hs, dd_vs, dd_bn}, rst_vec);
    end
    repeat (3) @(posedge clk);
    #2 resetN = 1'b1;
    // Outputs hold reset values for RGB_LAT edges, then show coordinate 0,0
    for (int e = 1; e <= 4; e++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (px[k] !== 11'(e) || py[k] !== 11'd0) begin
          errors++;
          $display("FAIL restart_coord lat%0d edge%0d: got %0d,%0d expected %0d,0",
                   LATS[k], e, px[k], py[k], e);
        end
        if (e <= LATS[k]) begin
          checks++;
          if ({rr[k], gg[k], bb[k], hs[k], vs[k], bn[k]} !== {24'd0, 3'b110}) begin
            errors++;
            $display("FAIL reset_hold lat%0d edge%0d: got %h expected %h", LATS[k], e,
                     {rr[k], gg[k], bb[k], hs[k], vs[k], bn[k]}, {24'd0, 3'b110});
          end
        end else if (e == LATS[k] + 1) begin
          checks++;
          if ({hs[k], vs[k], bn[k]} !== 3'b111) begin
            errors++;
            $display("FAIL first_visible lat%0d edge%0d: hs,vs,bn got %b expected 111",
                     LATS[k], e, {hs[k], vs[k], bn[k]});
          end
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    while (!(px[1] == 11'd19 && py[1] == 11'd4) && n < 2*FT) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2*FT) begin
      errors++;
      $display("FAIL midframe_wait: no hsync region reached in %0d clks", n);
      return;
    end
    tick();
    #2 resetN = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({px[k], py[k], sof[k], hs[k], vs[k], bn[k]} !== {22'd0, 4'b1110}) begin
        errors++;
        $display("FAIL midframe_reset lat%0d: x=%0d y=%0d sof=%b hs=%b vs=%b bn=%b",
                 LATS[k], px[k], py[k], sof[k], hs[k], vs[k], bn[k]);
      end
    end
    @(posedge clk);
    #2 resetN = 1'b1;
    tick();
    checks++;
    if (px[2] !== 11'd1 || py[2] !== 11'd0 || hs[2] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_restart: x=%0d y=%0d hs=%b expected 1 0 1", px[2], py[2], hs[2]);
    end
  endtask

  task automatic test_free_run();
    int bad_coord = 0, bad_sof = 0, bad_full = 0, bad_period = 0;
    int n_sof = 0, last_sof = -1;
    int h, v;
    apply_reset();
    for (int t = 1; t <= 2*FT + 10; t++) begin
      tick();
      h = t % HT;
      v = (t / HT) % VT;
      for (int k = 0; k < 3; k++) begin
        if (px[k] !== 11'(h) || py[k] !== 11'(v)) bad_coord++;
        if (sof[k] !== (h == 0 && v == 0)) bad_sof++;
      end
      if (dd_px !== 11'(t % 800) || dd_py !== 11'(t / 800) || dd_sof !== 1'b0) bad_full++;
      if (sof[1]) begin
        if (last_sof >= 0 && t - last_sof != FT) bad_period++;
        last_sof = t;
        n_sof++;
      end
    end
    checks++;
    if (bad_coord != 0) begin
      errors++;
      $display("FAIL free_run_coord: %0d mismatching samples, expected 0", bad_coord);
    end
    checks++;
    if (bad_sof != 0) begin
      errors++;
      $display("FAIL free_run_sof: %0d mismatching samples, expected 0", bad_sof);
    end
    checks++;
    if (bad_full != 0) begin
      errors++;
      $display("FAIL free_run_full_coord: %0d mismatching samples, expected 0", bad_full);
    end
    checks++;
    if (n_sof != 2 || bad_period != 0) begin
      errors++;
      $display("FAIL sof_period: pulses=%0d bad_periods=%0d expected 2 and 0", n_sof, bad_period);
    end
  endtask

  task automatic test_line_timing();
    int n = 0, x18 = -1, x656 = -1, full_lo = 0, full_bn = 0, full_fall = -1;
    int lo [3], hi [3], fall [3];
    logic prev [3];
    logic prev_full;
    while (!(px[1] == 11'd0 && py[1] == 11'd2) && n < 2*FT) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2*FT) begin
      errors++;
      $display("FAIL line_wait: line start not seen in %0d clks", n);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      lo[k] = 0; hi[k] = 0; fall[k] = -1;
    end
    for (int i = 0; i < HT; i++) begin
      if (i > 0) tick();
      if (px[1] == 11'd18) x18 = i;
      for (int k = 0; k < 3; k++) begin
        if (!hs[k]) lo[k]++;
        if (bn[k]) hi[k]++;
        if (i > 0 && prev[k] && !hs[k] && fall[k] < 0) fall[k] = i;
        prev[k] = hs[k];
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lo[k] != HS) begin
        errors++;
        $display("FAIL hsync_width lat%0d: got %0d expected %0d", LATS[k], lo[k], HS);
      end
      checks++;
      if (hi[k] != HV) begin
        errors++;
        $display("FAIL blank_width lat%0d: got %0d expected %0d", LATS[k], hi[k], HV);
      end
      checks++;
      if (fall[k] - x18 != LATS[k] + 1) begin
        errors++;
        $display("FAIL hsync_fall lat%0d: delay got %0d expected %0d", LATS[k], fall[k] - x18, LATS[k] + 1);
      end
    end
    n = 0;
    while (dd_px != 11'd0 && n < 900) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 900) begin
      errors++;
      $display("FAIL full_line_wait: line start not seen in %0d clks", n);
      return;
    end
    prev_full = dd_hs;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      if (dd_px == 11'd656) x656 = i;
      if (!dd_hs) full_lo++;
      if (dd_bn) full_bn++;
      if (i > 0 && prev_full && !dd_hs && full_fall < 0) full_fall = i;
      prev_full = dd_hs;
    end
    checks++;
    if (full_lo != 96) begin
      errors++;
      $display("FAIL full_hsync_width: got %0d expected 96", full_lo);
    end
    checks++;
    if (full_bn != 640) begin
      errors++;
      $display("FAIL full_blank_width: got %0d expected 640", full_bn);
    end
    checks++;
    if (full_fall - x656 != 2) begin
      errors++;
      $display("FAIL full_hsync_fall: delay got %0d expected 2", full_fall - x656);
    end
  endtask

  task automatic test_frame_timing();
    int n = 0, tv = -1;
    int lo [3], fall [3], hlo [3];
    logic prev [3];
    while (!(px[1] == 11'd0 && py[1] == 11'd0) && n < 2*FT) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2*FT) begin
      errors++;
      $display("FAIL frame_wait: frame start not seen in %0d clks", n);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      lo[k] = 0; fall[k] = -1; hlo[k] = 0;
    end
    for (int i = 0; i < FT; i++) begin
      if (i > 0) tick();
      if (px[1] == 11'd0 && py[1] == 11'd10) tv = i;
      for (int k = 0; k < 3; k++) begin
        if (!vs[k]) lo[k]++;
        if (!hs[k]) hlo[k]++;
        if (i > 0 && prev[k] && !vs[k] && fall[k] < 0) fall[k] = i;
        prev[k] = vs[k];
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lo[k] != VS*HT) begin
        errors++;
        $display("FAIL vsync_width lat%0d: got %0d expected %0d", LATS[k], lo[k], VS*HT);
      end
      checks++;
      if (fall[k] - tv != LATS[k] + 1) begin
        errors++;
        $display("FAIL vsync_fall lat%0d: delay got %0d expected %0d", LATS[k], fall[k] - tv, LATS[k] + 1);
      end
      checks++;
      if (hlo[k] != VT*HS) begin
        errors++;
        $display("FAIL hsync_per_frame lat%0d: got %0d expected %0d", LATS[k], hlo[k], VT*HS);
      end
    end
  endtask

  task automatic test_blank_black();
    int bad [3], hi [3];
    RGBIn = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      bad[k] = 0; hi[k] = 0;
    end
    for (int i = 0; i < FT; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        if (bn[k]) begin
          hi[k]++;
          if ({rr[k], gg[k], bb[k]} !== 24'hFFFFFF) bad[k]++;
        end else if ({rr[k], gg[k], bb[k]} !== 24'h000000) begin
          bad[k]++;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bad[k] != 0) begin
        errors++;
        $display("FAIL colour_vs_blank lat%0d: %0d samples disagree, expected 0", LATS[k], bad[k]);
      end
      checks++;
      if (hi[k] != HV*VV) begin
        errors++;
        $display("FAIL visible_per_frame lat%0d: got %0d expected %0d", LATS[k], hi[k], HV*VV);
      end
    end
  endtask

  task automatic test_colour();
    logic [7:0]  vec [7];
    logic [23:0] exp_rgb [7];
    int n = 0;
    vec = '{8'hE0, 8'h49, 8'hFF, 8'h80, 8'h1C, 8'h03, 8'h22};
    exp_rgb = '{24'hFF0000, 24'h494955, 24'hFFFFFF, 24'h920000,
                24'h00FF00, 24'h0000FF, 24'h2400AA};
    while (!(px[1] == 11'd6 && py[1] == 11'd3) && n < 2*FT) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2*FT) begin
      errors++;
      $display("FAIL colour_wait: visible pixel not reached in %0d clks", n);
      return;
    end
    // New pixel every clock: each vector appears on the very next clock
    for (int j = 0; j < 7; j++) begin
      RGBIn = vec[j];
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rr[k], gg[k], bb[k]} !== exp_rgb[j]) begin
          errors++;
          $display("FAIL colour lat%0d in=%h: got %h expected %h", LATS[k], vec[j],
                   {rr[k], gg[k], bb[k]}, exp_rgb[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_line_timing();
    test_frame_timing();
    test_blank_black();
    test_colour();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
